// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial pattern detector. Watches a 1-bit stream (qualified by en) for an
// MSB-first PATTERN of PAT_LEN bits. Each match pulses `match` for one cycle
// and bumps a saturating match counter. With STICKY=1 the first match locks
// the block and raises `start_shifting` until clear/reset; with STICKY=0 the
// search continues, with overlapping (OVERLAP=1) or non-overlapping matches.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high; clears all state
//   clear          in   synchronous; back to SEARCH, window emptied,
//                       match_count preserved; wins over en
//   en             in   data is sampled this cycle when high
//   data           in   serial input bit
//   match          out  registered one-cycle pulse per detected match
//   start_shifting out  registered level, high while LOCKED (STICKY=1 only)
//   match_count    out  saturating count of matches since reset
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 STICKY  = 1'b1,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             data,
    output logic             match,
    output logic             start_shifting,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned       FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] win_q, win_d, win_shift;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
    logic               match_q, match_d;
    logic               start_q, start_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               accept;
    logic               hit;

    generate
        if (PAT_LEN < 1 || PAT_LEN > 32) begin : g_bad_len
            $error("seq_detect_param: PAT_LEN must be in 1..32");
        end

        // A one-bit window has no older bits to keep, so the slice form
        // below would be out of range.
        if (PAT_LEN == 1) begin : g_shift_one
            assign win_shift = data;
        end else begin : g_shift_many
            assign win_shift = {win_q[PAT_LEN-2:0], data};
        end
    endgenerate

    assign accept   = en && !clear && (state_q == SEARCH);
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    // Match is judged on the window as it will be after this bit, and only
    // once the window holds PAT_LEN genuinely received bits.
    assign hit = accept && (fill_inc == FILL_FULL) && (win_shift == PATTERN);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        count_d = count_q;

        if (clear) begin
            state_d = SEARCH;
            win_d   = '0;
            fill_d  = '0;
        end else if (accept) begin
            win_d  = win_shift;
            fill_d = fill_inc;
            if (hit) begin
                match_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                if (STICKY) begin
                    state_d = LOCKED;
                end else if (!OVERLAP) begin
                    // Non-overlapping: the matched bits must not seed the
                    // next match, so the window counts as empty again.
                    fill_d = '0;
                end
            end
        end

        // Registered copy of the next state so the level lines up with the
        // edge at which LOCKED is entered or left.
        start_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            start_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            start_q <= start_d;
            count_q <= count_d;
        end
    end

    assign match          = match_q;
    assign start_shifting = start_q;
    assign match_count    = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int NI = 5;

    // Per-instance configuration as seen by the reference model.
    //   0: defaults (1101, sticky, overlap)
    //   1: 1101 free-run overlap
    //   2: 1111 free-run overlap
    //   3: 1111 free-run non-overlap
    //   4: single-bit pattern 1, 2-bit counter
    localparam int PLEN [NI] = '{4, 4, 4, 4, 1};
    localparam int PATV [NI] = '{13, 13, 15, 15, 1};
    localparam int STK  [NI] = '{1, 0, 0, 0, 0};
    localparam int OVL  [NI] = '{1, 1, 1, 0, 1};
    localparam int CW   [NI] = '{8, 8, 8, 8, 2};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic en = 1'b0;
    logic data = 1'b0;

    logic       m_o   [NI];
    logic       ss_o  [NI];
    logic [7:0] cnt_o [NI];
    logic [1:0] cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detect_param u0 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data(data),
        .match(m_o[0]), .start_shifting(ss_o[0]), .match_count(cnt_o[0]));

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1101), .STICKY(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data(data),
        .match(m_o[1]), .start_shifting(ss_o[1]), .match_count(cnt_o[1]));

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1111), .STICKY(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data(data),
        .match(m_o[2]), .start_shifting(ss_o[2]), .match_count(cnt_o[2]));

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1111), .STICKY(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data(data),
        .match(m_o[3]), .start_shifting(ss_o[3]), .match_count(cnt_o[3]));

    seq_detect_param #(.PAT_LEN(1), .PATTERN(1'b1), .STICKY(1'b0), .OVERLAP(1'b1), .CNT_W(2)) u4 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data(data),
        .match(m_o[4]), .start_shifting(ss_o[4]), .match_count(cnt4));

    assign cnt_o[4] = {6'b0, cnt4};

    // ---------------- reference model ----------------
    // History of accepted bits since the window was last emptied; a match is
    // the most recent PAT_LEN bits read MSB-first equalling the pattern.
    bit hist [NI][$];
    bit locked [NI];
    int m_cnt [NI];
    bit m_match [NI];

    function automatic int hist_val(input int k);
        int v = 0;
        for (int i = 0; i < hist[k].size(); i++) v = v * 2 + int'(hist[k][i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            hist[k].delete();
            locked[k] = 1'b0;
            m_cnt[k] = 0;
            m_match[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit c, input bit e, input bit d);
        for (int k = 0; k < NI; k++) begin
            m_match[k] = 1'b0;
            if (c) begin
                hist[k].delete();
                locked[k] = 1'b0;
            end else if (e && !locked[k]) begin
                hist[k].push_back(d);
                if (hist[k].size() > PLEN[k]) void'(hist[k].pop_front());
                if (hist[k].size() == PLEN[k] && hist_val(k) == PATV[k]) begin
                    m_match[k] = 1'b1;
                    if (m_cnt[k] < (1 << CW[k]) - 1) m_cnt[k]++;
                    if (STK[k] != 0) locked[k] = 1'b1;
                    else if (OVL[k] == 0) hist[k].delete();
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Asserts reset between edges and checks outputs clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        en    = 1'b0;
        data  = 1'b0;
        #2;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_match_u%0d", k), {7'b0, m_o[k]}, 8'd0);
            check($sformatf("rst_start_u%0d", k), {7'b0, ss_o[k]}, 8'd0);
            check($sformatf("rst_count_u%0d", k), cnt_o[k], 8'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input bit c, input bit e, input bit d);
        clear = c;
        en    = e;
        data  = d;
        @(posedge clk);
        model_step(c, e, d);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int         inst;
        bit         rst;
        bit         clr;
        bit         en;
        bit         d;
        bit         m;
        bit         ss;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input int inst, input bit rst, input bit clr, input bit e,
                                input bit d, input bit m, input bit ss, input int cnt);
        vec_t v;
        v.inst = inst; v.rst = rst; v.clr = clr; v.en = e; v.d = d;
        v.m = m; v.ss = ss; v.cnt = 8'(cnt);
        vt.push_back(v);
    endfunction

    initial begin
        // Defaults: 0,1,1,0,1 locks on bit 5, then 1,1,0,1 is ignored.
        add(0,1,0,1,0, 0,0,0); add(0,0,0,1,1, 0,0,0); add(0,0,0,1,1, 0,0,0);
        add(0,0,0,1,0, 0,0,0); add(0,0,0,1,1, 1,1,1);
        add(0,0,0,1,1, 0,1,1); add(0,0,0,1,1, 0,1,1); add(0,0,0,1,0, 0,1,1);
        add(0,0,0,1,1, 0,1,1);
        // Free-run overlap 1101: 1,1,0,1,1,0,1 matches on bits 4 and 7.
        add(1,1,0,1,1, 0,0,0); add(1,0,0,1,1, 0,0,0); add(1,0,0,1,0, 0,0,0);
        add(1,0,0,1,1, 1,0,1); add(1,0,0,1,1, 0,0,1); add(1,0,0,1,0, 0,0,1);
        add(1,0,0,1,1, 1,0,2);
        // 1111 overlap, six 1s: matches on bits 4,5,6.
        add(2,1,0,1,1, 0,0,0); add(2,0,0,1,1, 0,0,0); add(2,0,0,1,1, 0,0,0);
        add(2,0,0,1,1, 1,0,1); add(2,0,0,1,1, 1,0,2); add(2,0,0,1,1, 1,0,3);
        // 1111 non-overlap, six 1s: match on bit 4 only.
        add(3,1,0,1,1, 0,0,0); add(3,0,0,1,1, 0,0,0); add(3,0,0,1,1, 0,0,0);
        add(3,0,0,1,1, 1,0,1); add(3,0,0,1,1, 0,0,1); add(3,0,0,1,1, 0,0,1);
        // Defaults with en=0 gaps carrying junk data.
        add(0,1,0,1,1, 0,0,0); add(0,0,0,0,0, 0,0,0); add(0,0,0,1,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0); add(0,0,0,1,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
        add(0,0,0,0,1, 0,0,0); add(0,0,0,1,1, 1,1,1);
        // Single-bit pattern, 2-bit counter saturates at 3.
        add(4,1,0,1,1, 1,0,1); add(4,0,0,1,1, 1,0,2); add(4,0,0,1,1, 1,0,3);
        add(4,0,0,1,1, 1,0,3); add(4,0,0,1,1, 1,0,3);
        // clear together with the completing bit suppresses the match.
        add(0,1,0,1,1, 0,0,0); add(0,0,0,1,1, 0,0,0); add(0,0,0,1,0, 0,0,0);
        add(0,0,1,1,1, 0,0,0);
        add(0,0,0,1,1, 0,0,0); add(0,0,0,1,1, 0,0,0); add(0,0,0,1,0, 0,0,0);
        add(0,0,0,1,1, 1,1,1);
        // Lock, clear keeps the count, relock increments it.
        add(0,1,0,1,1, 0,0,0); add(0,0,0,1,1, 0,0,0); add(0,0,0,1,0, 0,0,0);
        add(0,0,0,1,1, 1,1,1); add(0,0,1,0,0, 0,0,1);
        add(0,0,0,1,1, 0,0,1); add(0,0,0,1,1, 0,0,1); add(0,0,0,1,0, 0,0,1);
        add(0,0,0,1,1, 1,1,2);

        #1;
        do_reset();

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            cycle(vt[i].clr, vt[i].en, vt[i].d);
            check($sformatf("vec%0d_match_u%0d", i, vt[i].inst), {7'b0, m_o[vt[i].inst]}, {7'b0, vt[i].m});
            check($sformatf("vec%0d_start_u%0d", i, vt[i].inst), {7'b0, ss_o[vt[i].inst]}, {7'b0, vt[i].ss});
            check($sformatf("vec%0d_count_u%0d", i, vt[i].inst), cnt_o[vt[i].inst], vt[i].cnt);
        end

        // Async reset while LOCKED: outputs must drop before the next edge.
        check("locked_before_reset", {7'b0, ss_o[0]}, 8'd1);
        do_reset();
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        check("post_reset_no_early_match", {7'b0, m_o[0]}, 8'd0);
        cycle(1'b0, 1'b1, 1'b1);
        check("post_reset_match", {7'b0, m_o[0]}, 8'd1);
        check("post_reset_count", cnt_o[0], 8'd1);
        check("post_reset_start", {7'b0, ss_o[0]}, 8'd1);

        // Randomised stream against the reference model on every instance.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
                for (int k = 0; k < NI; k++) begin
                    check($sformatf("rand%0d_match_u%0d", n, k), {7'b0, m_o[k]}, {7'b0, m_match[k]});
                    check($sformatf("rand%0d_start_u%0d", n, k), {7'b0, ss_o[k]}, {7'b0, locked[k]});
                    check($sformatf("rand%0d_count_u%0d", n, k), cnt_o[k], 8'(m_cnt[k]));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector with an optional lock mode. It watches a 1-bit data stream, qualified by `en`, for a configurable MSB-first pattern. On a match it pulses `match` and counts the match. In lock mode (`STICKY=1`) it raises `start_shifting` and holds it until reset or `clear`, which is the hand-off point into the downstream shift/count/timer FSMs. In free-run mode it keeps searching, with overlapping or non-overlapping match semantics.

## Interface
Parameters:
- `PAT_LEN`, 4: pattern length in bits. Legal range 1..32.
- `PATTERN`, 4'b1101: pattern to match, `PAT_LEN` bits wide. Bit `PAT_LEN-1` is the first bit received.
- `STICKY`, 1: 1 = lock after the first match; 0 = free-run, keep searching.
- `OVERLAP`, 1: 1 = the bits of a match may start the next match; 0 = the window is emptied after each match.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk`  in  1: the single clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state immediately.
- `clear`  in  1: synchronous. Returns the block to SEARCH and empties the window. `match_count` is preserved.
- `en`  in  1: when high, `data` is sampled this cycle.
- `data`  in  1: serial input bit.
- `match`  out  1: registered, one-cycle pulse per detected match.
- `start_shifting`  out  1: registered level. High while in LOCKED. Constant 0 when `STICKY=0`.
- `match_count`  out  `CNT_W`: number of matches since reset. Saturates at all-ones.

## Operation
- Window: `PAT_LEN`-bit shift register `win` plus fill counter `fill` (0..`PAT_LEN`).
  - On each accepted bit: `win <= {win[PAT_LEN-2:0], data}` and `fill` increments, saturating at `PAT_LEN`.
- Accepted bit: `en=1`, `clear=0`, and state is SEARCH.
- Match condition, evaluated on the next-state window: accepted bit, `fill_next == PAT_LEN`, and `win_next == PATTERN`.
- States:
  - SEARCH: shift on accepted bits.
    - On match with `STICKY=1`: go to LOCKED.
    - On match with `STICKY=0` and `OVERLAP=0`: set `fill <= 0`.
    - On match with `STICKY=0` and `OVERLAP=1`: `fill` stays at `PAT_LEN`.
  - LOCKED: `data`/`en` are ignored, `win` is frozen, and `start_shifting=1`. Only `clear` or `reset` exits, to SEARCH.
- On every match, `match_count` increments unless it is already all-ones.
- Reset values: state SEARCH; `win=0`; `fill=0`; `match=0`; `start_shifting=0`; `match_count=0`.
- `clear`: state SEARCH, `fill=0`, `win=0`, `match=0`, `start_shifting=0` on the next edge. It has priority over `en`; a bit presented with `clear` is discarded.
- Partial-match recovery is implicit in the window. For example, with 1101, stream 1,1,1,0,1 matches on the 5th bit.
- Elaboration must fail on `PAT_LEN` outside 1..32.

## Timing
- Latency: the completing bit is sampled at edge N. `match` is high from edge N to N+1. `match_count` updates at edge N. `start_shifting` rises at edge N (`STICKY=1`).
- Back-to-back matches (`OVERLAP=1`, for example pattern 1111 with continuous 1s): `match` stays high on consecutive cycles.
- `en=0` cycles are transparent: no shift, no fill change, `match=0`.
- `reset` asserted mid-stream, including in LOCKED: outputs go to reset values asynchronously, not at a clock edge. Release is synchronous to the following edge.
- `clear` in the same cycle as a completing bit: no match, no count increment.
- Saturation: once `match_count` is all-ones, further matches still pulse `match`, but the count holds.

## Test plan
- Defaults, send 0,1,1,0,1 with `en=1` -> `match` pulses once after the 5th bit. `start_shifting=1`, `match_count=1`. Then send 1,1,0,1 -> no further `match`; `start_shifting` stays 1.
- `STICKY=0`, `OVERLAP=1`, pattern 1101, send 1,1,0,1,1,0,1 -> `match` after bits 4 and 7. `match_count=2`, `start_shifting=0` throughout.
- `STICKY=0`, pattern 1111, six 1s -> `OVERLAP=1`: matches after bits 4, 5, 6, count 3. `OVERLAP=0`: match after bit 4 only, count 1.
- Defaults, send 1,1,0,1 with `en=0` gaps inserted between bits -> a single match after the last enabled bit. Bits presented with `en=0` are ignored.
- `STICKY=0`, `CNT_W=2`, pattern 1, send five 1s -> five `match` pulses; `match_count` ends at 3.
- Defaults: reach LOCKED, then pulse `clear` -> `start_shifting=0`, count kept at 1; a new 1101 relocks with count 2. Assert async `reset` between edges -> all outputs 0 before the next edge.
